// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing receiver: FSM encoding, default
// measurement width and the 1024x768@60 reference timing.
package video_timing_pkg;

  localparam int unsigned VT_DEFAULT_CW = 11;

  localparam int unsigned XGA_H_TOTAL = 1344;
  localparam int unsigned XGA_H_DISP  = 1024;
  localparam int unsigned XGA_V_TOTAL = 806;
  localparam int unsigned XGA_V_DISP  = 768;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    CHECK   = 2'd2,
    LOCKED  = 2'd3
  } vt_state_t;

endpackage

// File: rtl/vt_edge_det.sv
// Registered-input edge detector: the level output is the input register,
// and rise/fall pulses compare it against its previous value.
module vt_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      level <= din;
      prev  <= level;
    end
  end

  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/video_timing_rx.sv
// Video timing receiver: RGB888->RGB565 pixel path with active coordinates,
// frame timing measurement and a lock FSM that watches frame-to-frame stability.
module video_timing_rx
  import video_timing_pkg::*;
#(
  parameter int unsigned CW          = VT_DEFAULT_CW,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic          pixel_clk,
  input  logic          sys_rst_n,
  input  logic          video_hs,
  input  logic          video_vs,
  input  logic          video_de,
  input  logic [23:0]   video_rgb,
  output logic          pixel_valid,
  output logic [15:0]   pixel_rgb_565,
  output logic [CW-1:0] pixel_xpos,
  output logic [CW-1:0] pixel_ypos,
  output logic          frame_start,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_disp,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_disp,
  output logic          locked,
  output logic          timing_err
);

  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CW'(1);
  endfunction

  logic hs_lvl, hs_rise_c, hs_fall_c;
  logic vs_lvl, vs_rise_c, vs_fall_c;
  logic de_lvl, de_rise_c, de_fall_c;
  logic [23:0] rgb_r;

  logic [CW-1:0] x_cnt, y_cnt;
  logic [CW-1:0] h_cnt, de_cnt, last_h_total, frame_h_disp;
  logic [CW-1:0] v_cnt, vd_cnt, idle_cnt, v_disp_c;
  logic          line_de;
  logic [4*CW-1:0] ref_meas, meas_c;
  logic          timeout_c, match_c, ref_load_c, err_c;
  vt_state_t     state, state_d;
  logic [3:0]    match_cnt, match_d, match_inc_c;
  logic          unused_bits;

  vt_edge_det u_hs (.clk(pixel_clk), .rst_n(sys_rst_n), .din(video_hs),
                    .level(hs_lvl), .rise_c(hs_rise_c), .fall_c(hs_fall_c));
  vt_edge_det u_vs (.clk(pixel_clk), .rst_n(sys_rst_n), .din(video_vs),
                    .level(vs_lvl), .rise_c(vs_rise_c), .fall_c(vs_fall_c));
  vt_edge_det u_de (.clk(pixel_clk), .rst_n(sys_rst_n), .din(video_de),
                    .level(de_lvl), .rise_c(de_rise_c), .fall_c(de_fall_c));

  assign unused_bits = ^{hs_lvl, hs_rise_c, vs_lvl, vs_rise_c,
                         rgb_r[18:16], rgb_r[9:8], rgb_r[2:0]};

  // Pixel path: input register then output register, blanked outside de
  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      rgb_r         <= '0;
      pixel_valid   <= 1'b0;
      pixel_rgb_565 <= '0;
      pixel_xpos    <= '0;
      pixel_ypos    <= '0;
      x_cnt         <= '0;
      y_cnt         <= '0;
    end else begin
      rgb_r       <= video_rgb;
      pixel_valid <= de_lvl;
      if (de_lvl) begin
        pixel_rgb_565 <= {rgb_r[23:19], rgb_r[15:10], rgb_r[7:3]};
        pixel_xpos    <= de_rise_c ? '0 : x_cnt;
        pixel_ypos    <= y_cnt;
        x_cnt         <= de_rise_c ? CW'(1) : sat_inc(x_cnt);
      end else begin
        pixel_rgb_565 <= '0;
        pixel_xpos    <= '0;
        pixel_ypos    <= '0;
      end
      if (vs_fall_c)      y_cnt <= '0;
      else if (de_fall_c) y_cnt <= sat_inc(y_cnt);
    end
  end

  // Frame snapshot uses state before this cycle's hs edge: a coincident hs
  // fall becomes line 0 of the new frame.
  assign v_disp_c  = line_de ? sat_inc(vd_cnt) : vd_cnt;
  assign meas_c    = {last_h_total, frame_h_disp, v_cnt, v_disp_c};
  assign timeout_c = ~hs_fall_c & (idle_cnt == CMAX);

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      h_cnt <= '0; de_cnt <= '0; last_h_total <= '0; frame_h_disp <= '0;
      v_cnt <= '0; vd_cnt <= '0; idle_cnt <= '0; line_de <= 1'b0;
      h_total <= '0; h_disp <= '0; v_total <= '0; v_disp <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= vs_fall_c;
      h_cnt       <= hs_fall_c ? CW'(1) : sat_inc(h_cnt);
      idle_cnt    <= hs_fall_c ? '0 : sat_inc(idle_cnt);
      if (hs_fall_c) begin
        last_h_total <= h_cnt;
        de_cnt       <= de_lvl ? CW'(1) : '0;
      end else if (de_lvl) begin
        de_cnt <= sat_inc(de_cnt);
      end
      if (hs_fall_c || vs_fall_c) line_de <= de_lvl;
      else if (de_lvl)            line_de <= 1'b1;
      if (vs_fall_c) begin
        h_total      <= last_h_total;
        h_disp       <= frame_h_disp;
        v_total      <= v_cnt;
        v_disp       <= v_disp_c;
        frame_h_disp <= '0;
        vd_cnt       <= '0;
        v_cnt        <= hs_fall_c ? CW'(1) : '0;
      end else if (hs_fall_c) begin
        if (de_cnt != '0) frame_h_disp <= de_cnt;
        if (line_de)      vd_cnt       <= sat_inc(vd_cnt);
        v_cnt <= sat_inc(v_cnt);
      end
    end
  end

  assign match_c     = (meas_c == ref_meas);
  assign match_inc_c = match_cnt + 4'd1;

  // Lock FSM next-state logic
  always_comb begin
    state_d    = state;
    match_d    = match_cnt;
    ref_load_c = 1'b0;
    err_c      = 1'b0;
    if (timeout_c) begin
      state_d = SEARCH;
      match_d = '0;
    end else if (vs_fall_c) begin
      unique case (state)
        SEARCH:  state_d = MEASURE;
        MEASURE: begin
          state_d    = CHECK;
          ref_load_c = 1'b1;
          match_d    = 4'd1;
        end
        CHECK: begin
          if (match_c) begin
            match_d = match_inc_c;
            if (match_inc_c >= 4'(LOCK_FRAMES)) state_d = LOCKED;
          end else begin
            ref_load_c = 1'b1;
            match_d    = 4'd1;
          end
        end
        LOCKED: begin
          if (!match_c) begin
            state_d    = CHECK;
            ref_load_c = 1'b1;
            match_d    = 4'd1;
            err_c      = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      state      <= SEARCH;
      match_cnt  <= '0;
      ref_meas   <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_d;
      match_cnt  <= match_d;
      locked     <= (state_d == LOCKED);
      timing_err <= err_c;
      if (ref_load_c) ref_meas <= meas_c;
    end
  end

endmodule
